bank_read_unshift: RTL and testbench
====================================

# bank_read_unshift

Read-side alignment stage of the shared-cache switch. Each cycle it issues a read slot to the shared banks and takes the N lanes the banks return. It then rotates those lanes back to their output ports through a log2(N)-stage registered rotator, undoing the write-side rotation. It sits between the bank read data and the per-port output queues, and optionally checks that every delivered word's destination field matches the port it lands on.

## Interface
- PORT_NUB, 8: number of ports/banks; power of two, ≥2. WIDTH_SEL = log2(PORT_NUB).
- DATA_WIDTH, 32: payload width.
- RD_LAT, 1: bank read latency in cycles, 0..4. Slot shown → matching bank_in.
- Lane format, WIDTH_PORT = 1+2*WIDTH_SEL+DATA_WIDTH bits, packed {valid, src, dst, data}, valid at MSB. Lane i occupies bits [(i+1)*WIDTH_PORT-1 : i*WIDTH_PORT].
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  advance the slot counter.
- flush  in  1  synchronous pipeline clear.
- slot  out  WIDTH_SEL  current read slot, to bank addressing.
- bank_in  in  PORT_NUB*WIDTH_PORT  lanes returned by banks, RD_LAT cycles after the slot.
- port_out  out  PORT_NUB*WIDTH_PORT  aligned output lanes, one per port.
- port_valid  out  PORT_NUB  copy of each port_out lane's valid bit.
- busy  out  1  any valid word in the delay/rotator pipeline.
- err_dst  out  1  sticky destination-mismatch flag.
- err_port  out  WIDTH_SEL  port of first mismatch.

## Operation
- Slot counter: 0..PORT_NUB-1.
  - Increments when en=1 and wraps from PORT_NUB-1 to 0.
  - Holds when en=0.
  - The slot value is also pushed into an RD_LAT-deep shift register, so the rotation amount s that arrives with bank_in is the slot shown RD_LAT cycles earlier. With RD_LAT=0, s = slot.
- Input gating: a bank_in lane with valid=0 is replaced by all-zeros before stage 0.
- Rotator: WIDTH_SEL registered stages; s travels with the data, one register per stage.
  - Stage k: out[j] = in[(j+2^k) mod PORT_NUB] if bit k of s is 1, else in[j].
  - Net effect: port p receives bank lane (p+s) mod PORT_NUB.
- Pipeline stages advance every cycle regardless of en.
- busy = OR of valid bits in every rotator stage register and in the port_out register.
- Destination check (see Configuration): applied at the final stage for each port p. Condition: valid=1 and dst≠p.
- flush=1:
  - Slot counter, delay line, all rotator stage registers and port_out go to 0 on the next edge.
  - err_dst and err_port are retained.
  - flush beats en in the same cycle, so slot becomes 0.
- Reset: slot=0, port_out=0, port_valid=0, busy=0, err_dst=0, err_port=0, and all internal registers are 0. Asserting reset mid-flight discards every word in the pipeline.

## Timing
- bank_in → port_out: WIDTH_SEL cycles (3 for PORT_NUB=8).
- slot shown → port_out: RD_LAT+WIDTH_SEL cycles.
- port_valid is the same register bits as port_out, with no extra latency.
- err_dst/err_port update on the same edge that the offending word would appear on port_out.
- Mismatches on several ports in one cycle: err_port takes the lowest index.
- Later mismatches while err_dst=1 do not change err_port.
- Full throughput: one N-lane word set per cycle, no stalls, no backpressure.

## Configuration
- BANK_UNSHIFT_DST_CHECK_EN defined:
  - A mismatching word is dropped: its port_out lane is zeroed and its port_valid is 0.
  - err_dst is set; err_port records the port as above.
- Macro undefined:
  - No check; mismatching words are forwarded unchanged.
  - err_dst and err_port are tied to 0.

## Test plan
All scenarios: PORT_NUB=8, DATA_WIDTH=32, RD_LAT=1.
- Reset, then en=1 held for 10 cycles → slot reads 0,1,…,7,0,1. Drop en for 2 cycles → slot holds.
- Slot 3 shown; next cycle bank_in lane 5 = {1,src=1,dst=2,0xDEADBEEF}, other lanes invalid → 3 cycles later port 2 carries that word, port_valid=8'b0000_0100, all other lanes zero.
- s=7, all lanes valid, lane b dst=(b+1)%8, data=b → port p carries data (p+7)%8 (port 0 gets 7, port 1 gets 0), port_valid=8'hFF, err_dst stays 0.
- With macro: s=0, lane 2 dst=4 → port_valid[2]=0, err_dst=1, err_port=2. A later mismatch on port 6 leaves err_port=2. Without macro: port 2 forwards the word, err_dst=0.
- Words in flight plus flush=1 and en=1 in the same cycle → next cycle slot=0, port_valid=0, busy=0; err_dst is unchanged.
- Invalid lane with data=0xFFFFFFFF and nonzero src/dst → corresponding port_out lane all zeros.

Source files
------------

// File: rtl/bank_read_unshift.sv
// Read-side unshift: issues bank read slots and rotates returned lanes back to their ports.
// Latency: bank_in -> port_out WIDTH_SEL cycles; slot shown -> port_out RD_LAT+WIDTH_SEL cycles.
// Backpressure: none; accepts one N-lane word set every cycle, pipeline always advances.
//
// Ports:
//   clk, rst_n (sync, active-low), en (advance slot), flush (sync pipeline clear)
//   slot       : current read slot driven to bank addressing
//   bank_in    : N lanes {valid, src, dst, data} returned RD_LAT cycles after slot
//   port_out   : aligned lanes, lane p belongs to output port p; port_valid mirrors valid bits
//   busy       : any valid word held in the rotator / output registers
//   err_dst/err_port : sticky destination mismatch flag and first offending port
// Optional feature macro: BANK_UNSHIFT_DST_CHECK_EN (drop words whose dst does not match the port).

module bank_read_unshift #(
  parameter int PORT_NUB   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1,
  localparam int WIDTH_SEL  = $clog2(PORT_NUB),
  localparam int WIDTH_PORT = 1 + 2*WIDTH_SEL + DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           flush,
  output logic [WIDTH_SEL-1:0]           slot,
  input  logic [PORT_NUB*WIDTH_PORT-1:0] bank_in,
  output logic [PORT_NUB*WIDTH_PORT-1:0] port_out,
  output logic [PORT_NUB-1:0]            port_valid,
  output logic                           busy,
  output logic                           err_dst,
  output logic [WIDTH_SEL-1:0]           err_port
);

  typedef logic [PORT_NUB-1:0][WIDTH_PORT-1:0] vec_t;

  // Slot counter; power-of-two size means natural overflow is the wrap.
  logic [WIDTH_SEL-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (flush)   slot_d = '0;
    else if (en) slot_d = slot_q + WIDTH_SEL'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot = slot_q;

  // Rotation amount aligned with the bank data it applies to.
  logic [WIDTH_SEL-1:0] s_in;

  if (RD_LAT == 0) begin : g_nodly
    assign s_in = slot_q;
  end else begin : g_dly
    logic [WIDTH_SEL-1:0] dly_q [RD_LAT];
    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        for (int i = 0; i < RD_LAT; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= slot_q;
        for (int i = 1; i < RD_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign s_in = dly_q[RD_LAT-1];
  end

  // Invalid lanes are squashed to zero so stale src/dst/data never propagates.
  vec_t bank_v, gated;
  assign bank_v = bank_in;

  for (genvar i = 0; i < PORT_NUB; i++) begin : g_gate
    assign gated[i] = bank_v[i][WIDTH_PORT-1] ? bank_v[i] : '0;
  end

  // st_in[k] / sl_in[k] are the data and rotation amount entering stage k;
  // st_in[WIDTH_SEL] is the port_out register.
  vec_t                 st_in [WIDTH_SEL+1];
  logic [WIDTH_SEL-1:0] sl_in [WIDTH_SEL];

  assign st_in[0] = gated;
  assign sl_in[0] = s_in;

  for (genvar k = 0; k < WIDTH_SEL; k++) begin : g_stage
    vec_t rot_v;

    // Stage k rotates by 2^k lanes when bit k of the amount is set.
    for (genvar j = 0; j < PORT_NUB; j++) begin : g_rot
      assign rot_v[j] = sl_in[k][k] ? st_in[k][(j + (1 << k)) % PORT_NUB] : st_in[k][j];
    end

    if (k < WIDTH_SEL-1) begin : g_mid
      vec_t                 dat_q;
      logic [WIDTH_SEL-1:0] sel_q;
      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          dat_q <= '0;
          sel_q <= '0;
        end else begin
          dat_q <= rot_v;
          sel_q <= sl_in[k];
        end
      end
      assign st_in[k+1] = dat_q;
      assign sl_in[k+1] = sel_q;
    end else begin : g_last
      vec_t out_d, out_q;

`ifdef BANK_UNSHIFT_DST_CHECK_EN
      logic [PORT_NUB-1:0]  mism;
      logic                 err_dst_q;
      logic [WIDTH_SEL-1:0] err_port_q, first_p;

      for (genvar p = 0; p < PORT_NUB; p++) begin : g_chk
        assign mism[p]  = rot_v[p][WIDTH_PORT-1] &&
                          (rot_v[p][DATA_WIDTH +: WIDTH_SEL] != WIDTH_SEL'(p));
        assign out_d[p] = mism[p] ? '0 : rot_v[p];
      end

      // Descending scan so the lowest mismatching port wins.
      always_comb begin
        first_p = '0;
        for (int p = PORT_NUB-1; p >= 0; p--) begin
          if (mism[p[WIDTH_SEL-1:0]]) first_p = p[WIDTH_SEL-1:0];
        end
      end

      // Sticky: only the first mismatch is recorded; flush keeps the record.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          err_dst_q  <= 1'b0;
          err_port_q <= '0;
        end else if (!flush && !err_dst_q && (|mism)) begin
          err_dst_q  <= 1'b1;
          err_port_q <= first_p;
        end
      end

      assign err_dst  = err_dst_q;
      assign err_port = err_port_q;
`else
      assign out_d    = rot_v;
      assign err_dst  = 1'b0;
      assign err_port = '0;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n || flush) out_q <= '0;
        else                 out_q <= out_d;
      end
      assign st_in[WIDTH_SEL] = out_q;
    end
  end

  assign port_out = st_in[WIDTH_SEL];

  logic [WIDTH_SEL*PORT_NUB-1:0] vbits;

  for (genvar k = 1; k <= WIDTH_SEL; k++) begin : g_busy
    for (genvar p = 0; p < PORT_NUB; p++) begin : g_lane
      assign vbits[(k-1)*PORT_NUB + p] = st_in[k][p][WIDTH_PORT-1];
    end
  end

  assign busy = |vbits;

  for (genvar p = 0; p < PORT_NUB; p++) begin : g_pv
    assign port_valid[p] = st_in[WIDTH_SEL][p][WIDTH_PORT-1];
  end

endmodule

// File: tb/tb_bank_read_unshift.sv
module tb_bank_read_unshift;
  localparam int N  = 8;
  localparam int WS = 3;
  localparam int DW = 32;
  localparam int WP = 1 + 2*WS + DW;
`ifdef BANK_UNSHIFT_DST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, en, flush;
  logic [WS-1:0]   slot;
  logic [N*WP-1:0] bank_in;
  logic [N*WP-1:0] port_out;
  logic [N-1:0]    port_valid;
  logic            busy, err_dst;
  logic [WS-1:0]   err_port;

  int checks = 0;
  int errors = 0;

  bank_read_unshift #(.PORT_NUB(N), .DATA_WIDTH(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .slot(slot),
    .bank_in(bank_in), .port_out(port_out), .port_valid(port_valid),
    .busy(busy), .err_dst(err_dst), .err_port(err_port)
  );

  always #5 clk = ~clk;

  function automatic logic [WP-1:0] mk(input logic v, input logic [WS-1:0] s,
                                       input logic [WS-1:0] d, input logic [DW-1:0] dat);
    return {v, s, d, dat};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; bank_in = '1;
    tick(); tick();
    checks++; if (slot !== 3'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", slot); end
    checks++; if (port_out !== '0) begin errors++; $display("FAIL reset_port_out: got %h expected 0", port_out); end
    checks++; if (port_valid !== 8'h00) begin errors++; $display("FAIL reset_port_valid: got %h expected 00", port_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err_dst !== 1'b0) begin errors++; $display("FAIL reset_err_dst: got %b expected 0", err_dst); end
    checks++; if (err_port !== 3'd0) begin errors++; $display("FAIL reset_err_port: got %0d expected 0", err_port); end
    bank_in = '0; en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_slot_counter();
    logic [WS-1:0] exp_s;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_s = WS'(i % N);
      checks++; if (slot !== exp_s) begin errors++; $display("FAIL slot_count[%0d]: got %0d expected %0d", i, slot, exp_s); end
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (slot !== 3'd2) begin errors++; $display("FAIL slot_hold[%0d]: got %0d expected 2", i, slot); end
      tick();
    end
    checks++; if (slot !== 3'd2) begin errors++; $display("FAIL slot_hold_end: got %0d expected 2", slot); end
  endtask

  task automatic test_single_word();
    logic [N*WP-1:0] exp;
    do_flush();
    en = 1'b1; tick(); tick(); tick();
    en = 1'b0;
    checks++; if (slot !== 3'd3) begin errors++; $display("FAIL single_slot: got %0d expected 3", slot); end
    tick();
    bank_in = '0;
    bank_in[5*WP +: WP] = mk(1'b1, 3'd1, 3'd2, 32'hDEADBEEF);
    tick();
    bank_in = '0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_inflight: got %b expected 1", busy); end
    tick();
    exp = '0;
    exp[2*WP +: WP] = mk(1'b1, 3'd1, 3'd2, 32'hDEADBEEF);
    checks++; if (port_out !== exp) begin errors++; $display("FAIL single_port_out: got %h expected %h", port_out, exp); end
    checks++; if (port_valid !== 8'b0000_0100) begin errors++; $display("FAIL single_port_valid: got %b expected 00000100", port_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_out: got %b expected 1", busy); end
    tick();
    checks++; if (port_valid !== 8'h00) begin errors++; $display("FAIL single_drain_valid: got %b expected 0", port_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_drain_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rotate_full();
    logic [WP-1:0] exp_l;
    int b;
    do_flush();
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    en = 1'b0;
    tick();
    for (int k = 0; k < N; k++) bank_in[k*WP +: WP] = mk(1'b1, 3'd0, WS'((k+1) % N), DW'(k));
    tick();
    bank_in = '0;
    tick(); tick();
    for (int p = 0; p < N; p++) begin
      b = (p + 7) % N;
      exp_l = mk(1'b1, 3'd0, WS'((b+1) % N), DW'(b));
      checks++; if (port_out[p*WP +: WP] !== exp_l) begin errors++; $display("FAIL rot7_port[%0d]: got %h expected %h", p, port_out[p*WP +: WP], exp_l); end
    end
    checks++; if (port_valid !== 8'hFF) begin errors++; $display("FAIL rot7_port_valid: got %h expected ff", port_valid); end
    checks++; if (err_dst !== 1'b0) begin errors++; $display("FAIL rot7_err_dst: got %b expected 0", err_dst); end
  endtask

  task automatic test_invalid_lane();
    logic [N*WP-1:0] exp;
    do_flush();
    en = 1'b0;
    bank_in = '0;
    bank_in[3*WP +: WP] = mk(1'b0, 3'd5, 3'd6, 32'hFFFFFFFF);
    bank_in[1*WP +: WP] = mk(1'b1, 3'd2, 3'd1, 32'hA5A5A5A5);
    tick();
    bank_in = '0;
    tick(); tick();
    exp = '0;
    exp[1*WP +: WP] = mk(1'b1, 3'd2, 3'd1, 32'hA5A5A5A5);
    checks++; if (port_out[3*WP +: WP] !== '0) begin errors++; $display("FAIL invalid_lane3: got %h expected 0", port_out[3*WP +: WP]); end
    checks++; if (port_out !== exp) begin errors++; $display("FAIL invalid_port_out: got %h expected %h", port_out, exp); end
    checks++; if (port_valid !== 8'b0000_0010) begin errors++; $display("FAIL invalid_port_valid: got %b expected 00000010", port_valid); end
  endtask

  task automatic test_dst_check();
    logic [N*WP-1:0] exp;
    do_flush();
    en = 1'b0;
    bank_in = '0;
    bank_in[2*WP +: WP] = mk(1'b1, 3'd3, 3'd4, 32'h12345678);
    tick();
    bank_in = '0;
    tick(); tick();
    exp = '0;
    if (!CHK) exp[2*WP +: WP] = mk(1'b1, 3'd3, 3'd4, 32'h12345678);
    checks++; if (port_out !== exp) begin errors++; $display("FAIL dst1_port_out: got %h expected %h", port_out, exp); end
    checks++; if (port_valid !== (CHK ? 8'h00 : 8'h04)) begin errors++; $display("FAIL dst1_port_valid: got %h expected %h", port_valid, (CHK ? 8'h00 : 8'h04)); end
    checks++; if (err_dst !== CHK) begin errors++; $display("FAIL dst1_err_dst: got %b expected %b", err_dst, CHK); end
    checks++; if (err_port !== (CHK ? 3'd2 : 3'd0)) begin errors++; $display("FAIL dst1_err_port: got %0d expected %0d", err_port, (CHK ? 2 : 0)); end
    bank_in[6*WP +: WP] = mk(1'b1, 3'd0, 3'd1, 32'h66666666);
    tick();
    bank_in = '0;
    tick(); tick();
    checks++; if (port_valid !== (CHK ? 8'h00 : 8'h40)) begin errors++; $display("FAIL dst2_port_valid: got %h expected %h", port_valid, (CHK ? 8'h00 : 8'h40)); end
    checks++; if (err_dst !== CHK) begin errors++; $display("FAIL dst2_err_dst: got %b expected %b", err_dst, CHK); end
    checks++; if (err_port !== (CHK ? 3'd2 : 3'd0)) begin errors++; $display("FAIL dst2_err_port: got %0d expected %0d", err_port, (CHK ? 2 : 0)); end
  endtask

  task automatic test_flush();
    en = 1'b1;
    for (int k = 0; k < N; k++) bank_in[k*WP +: WP] = mk(1'b1, 3'd0, WS'(k), DW'(100 + k));
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0; en = 1'b0; bank_in = '0;
    checks++; if (slot !== 3'd0) begin errors++; $display("FAIL flush_slot: got %0d expected 0", slot); end
    checks++; if (port_valid !== 8'h00) begin errors++; $display("FAIL flush_port_valid: got %h expected 00", port_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    checks++; if (err_dst !== CHK) begin errors++; $display("FAIL flush_err_dst: got %b expected %b", err_dst, CHK); end
    checks++; if (err_port !== (CHK ? 3'd2 : 3'd0)) begin errors++; $display("FAIL flush_err_port: got %0d expected %0d", err_port, (CHK ? 2 : 0)); end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
    checks++; if (port_valid !== 8'h00) begin errors++; $display("FAIL flush_valid_after: got %h expected 00", port_valid); end
  endtask

  task automatic test_reset_midflight();
    en = 1'b1;
    for (int k = 0; k < N; k++) bank_in[k*WP +: WP] = mk(1'b1, 3'd1, WS'(k), DW'(k));
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; en = 1'b0; bank_in = '0;
    checks++; if (slot !== 3'd0) begin errors++; $display("FAIL rstmid_slot: got %0d expected 0", slot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (err_dst !== 1'b0) begin errors++; $display("FAIL rstmid_err_dst: got %b expected 0", err_dst); end
    checks++; if (err_port !== 3'd0) begin errors++; $display("FAIL rstmid_err_port: got %0d expected 0", err_port); end
    tick(); tick();
    checks++; if (port_out !== '0) begin errors++; $display("FAIL rstmid_port_out: got %h expected 0", port_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b expected 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; bank_in = '0;
    test_reset();
    test_slot_counter();
    test_single_word();
    test_rotate_full();
    test_invalid_lane();
    test_dst_check();
    test_flush();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
